rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between NUM_REQ writeback sources
//  (ALU, LSU, MUL/DIV) using round-robin valid/ready arbitration.

---
 rtl/rf_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// The winning writeback is registered one cycle and driven to the register file.
// That in-flight write is bypassed onto both read ports.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_wd,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rf_reg_write,
    output logic [4:0]              rf_rd,
    output logic [XLEN-1:0]         rf_wd,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [XLEN-1:0]         rf_rd1,
    input  logic [XLEN-1:0]         rf_rd2,
    output logic [XLEN-1:0]         rd1,
    output logic [XLEN-1:0]         rd2
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      cand;
    logic [PW:0]        idx_w;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               xfer;
    logic [4:0]         sel_rd;
    logic [XLEN-1:0]    sel_wd;

    // Search ptr, ptr+1, ... (mod NUM_REQ) for the first valid requester.
    // Grant is also held off while in reset so nothing is offered before the
    // pointer is known.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx_w   = '0;
        cand    = '0;
        if (rst_n && !stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_w = {1'b0, ptr} + (PW+1)'(k);
                if (idx_w >= (PW+1)'(NUM_REQ)) begin
                    idx_w = idx_w - (PW+1)'(NUM_REQ);
                end
                cand = idx_w[PW-1:0];
                if (!found && req_valid[cand]) begin
                    grant[cand] = 1'b1;
                    gnt_idx     = cand;
                    found       = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = found;

    // Mux the granted requester's destination and data; grant is one-hot.
    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd = req_rd[5*i +: 5];
                sel_wd = req_wd[XLEN*i +: XLEN];
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at NUM_REQ-1.
    always_comb begin
        if (gnt_idx == PW'(NUM_REQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = gnt_idx + PW'(1);
        end
    end

    // Register the winning write; a write to x0 is consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            rf_reg_write <= 1'b0;
            rf_rd        <= '0;
            rf_wd        <= '0;
        end else if (xfer) begin
            ptr          <= ptr_nxt;
            rf_rd        <= sel_rd;
            rf_wd        <= sel_wd;
            rf_reg_write <= (sel_rd != 5'd0);
        end else begin
            rf_reg_write <= 1'b0;
        end
    end

    // Forward the in-flight registered write to readers; x0 always reads zero.
    always_comb begin
        if (rs1 == 5'd0) begin
            rd1 = '0;
        end else if (rf_reg_write && (rf_rd == rs1)) begin
            rd1 = rf_wd;
        end else begin
            rd1 = rf_rd1;
        end
        if (rs2 == 5'd0) begin
            rd2 = '0;
        end else if (rf_reg_write && (rf_rd == rs2)) begin
            rd2 = rf_wd;
        end else begin
            rd2 = rf_rd2;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic [N-1:0]    req_valid;
    logic [N*5-1:0]  req_rd;
    logic [N*XL-1:0] req_wd;
    logic [N-1:0]    req_ready;
    logic            rf_reg_write;
    logic [4:0]      rf_rd;
    logic [XL-1:0]   rf_wd;
    logic [4:0]      rs1, rs2;
    logic [XL-1:0]   rf_rd1, rf_rd2;
    logic [XL-1:0]   rd1, rd2;

    int checks = 0;
    int errors = 0;

    logic [4:0]    b_rd [N];
    logic [XL-1:0] b_wd [N];
    bit            pend [N];

    // Behavioural model state
    int            m_ptr;
    bit            m_we;
    logic [4:0]    m_rd;
    logic [XL-1:0] m_wd;

    rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_wd       (req_wd),
        .req_ready    (req_ready),
        .rf_reg_write (rf_reg_write),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .rd1          (rd1),
        .rd2          (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack per-requester fields onto the flat request buses.
    always_comb begin
        req_rd = '0;
        req_wd = '0;
        for (int i = 0; i < N; i++) begin
            req_rd[5*i +: 5]   = b_rd[i];
            req_wd[XL*i +: XL] = b_wd[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (!rst_n || stall) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [XL-1:0] exp_read(input logic [4:0] rs, input logic [XL-1:0] raw);
        if (rs == 5'd0) return '0;
        if (m_we && m_rd == rs) return m_wd;
        return raw;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_we  = 1'b0;
        m_rd  = '0;
        m_wd  = '0;
    endtask

    // Check all outputs mid-cycle, then advance one clock and update the model.
    task automatic tick(output int g);
        logic [N-1:0]  er;
        logic [4:0]    nrd;
        logic [XL-1:0] nwd;
        #2;
        g  = exp_grant();
        er = (g < 0) ? '0 : (N'(1) << g);
        chk("ready", 32'(req_ready), 32'(er));
        chk("rf_reg_write", 32'(rf_reg_write), 32'(m_we));
        chk("rf_rd", 32'(rf_rd), 32'(m_rd));
        chk("rf_wd", rf_wd, m_wd);
        chk("rd1", rd1, exp_read(rs1, rf_rd1));
        chk("rd2", rd2, exp_read(rs2, rf_rd2));
        nrd = (g < 0) ? 5'd0 : b_rd[g];
        nwd = (g < 0) ? '0 : b_wd[g];
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_ptr   = (g + 1) % N;
            m_we    = (nrd != 5'd0);
            m_rd    = nrd;
            m_wd    = nwd;
            pend[g] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    initial begin
        int g;
        model_reset();
        rst_n     = 1'b0;
        stall     = 1'b0;
        req_valid = '1;
        rs1       = 5'd0;
        rs2       = 5'd0;
        rf_rd1    = $urandom;
        rf_rd2    = $urandom;
        for (int i = 0; i < N; i++) begin
            b_rd[i] = 5'(i + 1);
            b_wd[i] = 32'h1000_0000 + 32'(i);
            pend[i] = 1'b0;
        end

        // Reset held with all valid: no grant, no write
        @(posedge clk); #1;
        tick(g);
        tick(g);
        rst_n = 1'b1;
        #2;
        chk("rel_grant0", 32'(req_ready), 32'h1);
        tick(g);

        // Rotation with all valid
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) b_rd[i] = 5'(8 + 3*k + i);
            tick(g);
            chk("rot_grant", 32'(g), 32'((k + 1) % N));
        end

        // Sparse requests: req2 alone, then req0+req1
        req_valid = 3'b100;
        tick(g);
        chk("sparse_a", 32'(g), 32'd2);
        req_valid = 3'b011;
        tick(g);
        chk("sparse_b", 32'(g), 32'd0);
        req_valid = 3'b010;
        tick(g);
        chk("sparse_c", 32'(g), 32'd1);

        // x0 write from req1 (ptr now 2)
        req_valid = 3'b010;
        b_rd[1]   = 5'd0;
        b_wd[1]   = 32'hDEAD_BEEF;
        tick(g);
        chk("x0_grant", 32'(g), 32'd1);
        req_valid = 3'b000;
        #2;
        chk("x0_we", 32'(rf_reg_write), 32'd0);
        tick(g);

        // Bypass: req0 writes x5 = 0x1234
        req_valid = 3'b001;
        b_rd[0]   = 5'd5;
        b_wd[0]   = 32'h0000_1234;
        tick(g);
        req_valid = 3'b000;
        rs1       = 5'd5;
        rs2       = 5'd0;
        rf_rd1    = 32'hAAAA_5555;
        rf_rd2    = 32'h5555_AAAA;
        #2;
        chk("byp_rd1", rd1, 32'h0000_1234);
        chk("byp_rd2", rd2, 32'h0);
        tick(g);

        // Stall with all valid, pending write drains
        b_rd[1]   = 5'd7;
        b_rd[2]   = 5'd9;
        req_valid = 3'b111;
        tick(g);
        chk("pre_stall", 32'(g), 32'd1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) tick(g);
        stall = 1'b0;
        tick(g);
        chk("post_stall", 32'(g), 32'd2);

        // Async reset while a write is registered
        req_valid = 3'b000;
        #2;
        chk("mid_we_set", 32'(rf_reg_write), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_we", 32'(rf_reg_write), 32'd0);
        chk("async_rd", 32'(rf_rd), 32'd0);
        @(posedge clk); #1;
        tick(g);
        rst_n = 1'b1;

        // Randomized traffic honouring the valid/ready rules
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    b_rd[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    b_wd[i] = $urandom;
                end
                req_valid[i] = pend[i];
            end
            stall  = ($urandom_range(0, 4) == 0);
            rs1    = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom);
            rs2    = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom);
            rf_rd1 = $urandom;
            rf_rd2 = $urandom;
            tick(g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
